// File: rtl/digit_pkg.sv
// rtl/digit_pkg.sv - shared types, constants and mod-10 helper for the digit-add interface
package digit_pkg;

   localparam int DIGIT_W   = 4;
   localparam int DIGIT_MOD = 10;
   localparam int NUM_CH    = 2;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      PULSE,
      GAP,
      DONE
   } state_t;

   // Fold a 4-bit value into 0..9; inputs 10..15 are at most one modulus over.
   function automatic logic [DIGIT_W-1:0] mod10(input logic [DIGIT_W-1:0] v);
      if (v >= DIGIT_W'(DIGIT_MOD)) begin
         return v - DIGIT_W'(DIGIT_MOD);
      end
      return v;
   endfunction

endpackage

// File: rtl/rise_edge_det.sv
// rtl/rise_edge_det.sv - synchronous-reset rising-edge detector
module rise_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic in,
   output logic pulse
);

   logic in_q;

   // Previous sample of the input; cleared so a level held through reset counts as a new edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_q <= 1'b0;
      end else begin
         in_q <= in;
      end
   end

   assign pulse = in & ~in_q;

endmodule

// File: rtl/digit_sender.sv
// rtl/digit_sender.sv - replays two staged BCD digits as timed add transactions
module digit_sender
   import digit_pkg::*;
#(
   parameter int SETUP_CYC = 1,
   parameter int HOLD_CYC  = 2,
   parameter int GAP_CYC   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               wr_sel,
   input  logic [DIGIT_W-1:0] wr_data,
   input  logic               send,
   output logic               select,
   output logic               add,
   output logic [DIGIT_W-1:0] data_out,
   output logic               busy,
   output logic               done
);

   localparam int MAX_SH  = (SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC;
   localparam int MAX_CYC = (MAX_SH > GAP_CYC) ? MAX_SH : GAP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

   logic [DIGIT_W-1:0] stage  [NUM_CH];
   logic [DIGIT_W-1:0] shadow [NUM_CH];

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               ch_q, ch_d;
   logic               load_shadow;
   logic               send_rise;

   logic               sel_d, add_d, busy_d, done_d;
   logic [DIGIT_W-1:0] data_d;

   rise_edge_det u_send_edge (
      .clk   (clk),
      .rst   (rst),
      .in    (send),
      .pulse (send_rise)
   );

   // Host-side staging; digits are normalised on the way in so the shadow copy is always BCD.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            stage[i] <= '0;
         end
      end else if (wr_en) begin
         stage[wr_sel] <= mod10(wr_data);
      end
   end

   // Snapshot taken at trigger; reads the pre-write stage so a coincident write is deferred.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= '0;
         end
      end else if (load_shadow) begin
         for (int i = 0; i < NUM_CH; i++) begin
            shadow[i] <= stage[i];
         end
      end
   end

   // Sequencer next-state and the output values the state being entered will present.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ch_d        = ch_q;
      load_shadow = 1'b0;

      case (state_q)
         IDLE: begin
            if (send_rise) begin
               state_d     = SETUP;
               ch_d        = 1'b0;
               cnt_d       = SETUP_LD;
               load_shadow = 1'b1;
            end
         end
         SETUP: begin
            if (cnt_q == '0) begin
               state_d = PULSE;
               cnt_d   = HOLD_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         PULSE: begin
            if (cnt_q == '0) begin
               state_d = GAP;
               cnt_d   = GAP_LD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         GAP: begin
            if (cnt_q == '0) begin
               if (!ch_q) begin
                  state_d = SETUP;
                  ch_d    = 1'b1;
                  cnt_d   = SETUP_LD;
               end else begin
                  state_d = DONE;
                  cnt_d   = '0;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
            cnt_d   = '0;
            ch_d    = 1'b0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
            ch_d    = 1'b0;
         end
      endcase

      sel_d  = 1'b0;
      add_d  = 1'b0;
      data_d = '0;
      busy_d = 1'b0;
      done_d = 1'b0;

      case (state_d)
         SETUP, PULSE, GAP: begin
            sel_d  = ch_d;
            data_d = load_shadow ? stage[0] : shadow[ch_d];
            add_d  = (state_d == PULSE);
            busy_d = 1'b1;
         end
         DONE: begin
            done_d = 1'b1;
         end
         default: begin
            sel_d = 1'b0;
         end
      endcase
   end

   // State, counter and registered receiver-facing outputs; reset aborts any transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         ch_q     <= 1'b0;
         select   <= 1'b0;
         add      <= 1'b0;
         data_out <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ch_q     <= ch_d;
         select   <= sel_d;
         add      <= add_d;
         data_out <= data_d;
         busy     <= busy_d;
         done     <= done_d;
      end
   end

endmodule

// File: tb/tb_digit_sender.sv
// tb/tb_digit_sender.sv - self-checking bench for digit_sender
module tb_digit_sender;

   logic       clk = 1'b0;
   logic       rst;
   logic       wr_en;
   logic       wr_sel;
   logic [3:0] wr_data;
   logic       send1, send2;

   logic       select1, add1, busy1, done1;
   logic [3:0] data1;
   logic       select2, add2, busy2, done2;
   logic [3:0] data2;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [7:0] q1[$];
   logic [7:0] q2[$];
   logic       mon_en = 1'b0;
   logic [7:0] act_m, exp_m;

   logic [3:0] acc[2];
   logic       add1_q;

   typedef struct {
      logic [3:0] w0, w1;
      logic [3:0] e0, e1;
      logic [3:0] r0, r1;
   } vec_t;
   vec_t tbl[5];

   always #5 clk = ~clk;

   digit_sender u_dut1 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .send(send1), .select(select1), .add(add1), .data_out(data1),
      .busy(busy1), .done(done1)
   );

   digit_sender #(.SETUP_CYC(3), .HOLD_CYC(1), .GAP_CYC(4)) u_dut2 (
      .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
      .send(send2), .select(select2), .add(add2), .data_out(data2),
      .busy(busy2), .done(done2)
   );

   // Behavioural two-channel mod-10 receiver driven by the default-timing sender.
   always @(posedge clk) begin
      add1_q <= add1;
      if (rst) begin
         acc[0] <= 4'd0;
         acc[1] <= 4'd0;
      end else if (add1 && !add1_q) begin
         acc[select1] <= 4'((int'(acc[select1]) + int'(data1)) % 10);
      end
   end

   function automatic logic [7:0] pk(input bit b, input bit d, input bit s, input bit a,
                                     input logic [3:0] v);
      return {b, d, s, a, v};
   endfunction

   task automatic push_xfer(input int which, input logic [3:0] d0, input logic [3:0] d1,
                            input int su, input int ho, input int ga);
      logic [3:0] d;
      for (int c = 0; c < 2; c++) begin
         d = (c == 0) ? d0 : d1;
         for (int k = 0; k < su; k++) if (which == 1) q1.push_back(pk(1, 0, c[0], 0, d)); else q2.push_back(pk(1, 0, c[0], 0, d));
         for (int k = 0; k < ho; k++) if (which == 1) q1.push_back(pk(1, 0, c[0], 1, d)); else q2.push_back(pk(1, 0, c[0], 1, d));
         for (int k = 0; k < ga; k++) if (which == 1) q1.push_back(pk(1, 0, c[0], 0, d)); else q2.push_back(pk(1, 0, c[0], 0, d));
      end
      if (which == 1) q1.push_back(pk(0, 1, 0, 0, 4'd0)); else q2.push_back(pk(0, 1, 0, 0, 4'd0));
   endtask

   // Scoreboard: every cycle a DUT shows busy or done, its outputs must match the next expectation.
   always @(negedge clk) begin
      if (mon_en) begin
         act_m = {busy1, done1, select1, add1, data1};
         if (busy1 || done1) begin
            n_cmp++;
            if (q1.size() == 0) begin
               n_fail++;
               $display("FAIL dut1_unexpected_xfer actual=%h required=idle t=%0t", act_m, $time);
            end else begin
               exp_m = q1.pop_front();
               if (act_m !== exp_m) begin
                  n_fail++;
                  $display("FAIL dut1_cycle actual=%h required=%h t=%0t", act_m, exp_m, $time);
               end
            end
         end
         act_m = {busy2, done2, select2, add2, data2};
         if (busy2 || done2) begin
            n_cmp++;
            if (q2.size() == 0) begin
               n_fail++;
               $display("FAIL dut2_unexpected_xfer actual=%h required=idle t=%0t", act_m, $time);
            end else begin
               exp_m = q2.pop_front();
               if (act_m !== exp_m) begin
                  n_fail++;
                  $display("FAIL dut2_cycle actual=%h required=%h t=%0t", act_m, exp_m, $time);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_cmp++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic wr(input logic s, input logic [3:0] d);
      wr_en = 1'b1; wr_sel = s; wr_data = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic trig1(input logic [3:0] e0, input logic [3:0] e1);
      send1 = 1'b1;
      push_xfer(1, e0, e1, 1, 2, 2);
      tick();
      send1 = 1'b0;
      tick();
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((q1.size() != 0 || q2.size() != 0) && n < 200) begin
         tick();
         n++;
      end
      if (n >= 200) begin
         n_cmp++;
         n_fail++;
         $display("FAIL wait_idle_timeout actual=%0d/%0d required=0/0", q1.size(), q2.size());
         q1.delete();
         q2.delete();
      end
      repeat (3) tick();
   endtask

   initial begin
      bit found;
      tbl[0] = '{w0: 4'd7,  w1: 4'd5,  e0: 4'd7, e1: 4'd5, r0: 4'd7, r1: 4'd5};
      tbl[1] = '{w0: 4'd12, w1: 4'd15, e0: 4'd2, e1: 4'd5, r0: 4'd9, r1: 4'd0};
      tbl[2] = '{w0: 4'd0,  w1: 4'd9,  e0: 4'd0, e1: 4'd9, r0: 4'd9, r1: 4'd9};
      tbl[3] = '{w0: 4'd10, w1: 4'd11, e0: 4'd0, e1: 4'd1, r0: 4'd9, r1: 4'd0};
      tbl[4] = '{w0: 4'd9,  w1: 4'd0,  e0: 4'd9, e1: 4'd0, r0: 4'd8, r1: 4'd0};

      rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_data = 4'd0; send1 = 1'b0; send2 = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      chk("rst_busy", busy1, 0);
      chk("rst_add", add1, 0);
      chk("rst_select", select1, 0);
      chk("rst_data", data1, 0);
      chk("rst_done", done1, 0);
      chk("rst_busy2", busy2, 0);
      mon_en = 1'b1;

      // Table: staging with mod-10 folding, transfer, receiver accumulation.
      for (int i = 0; i < 5; i++) begin
         wr(1'b0, tbl[i].w0);
         wr(1'b1, tbl[i].w1);
         trig1(tbl[i].e0, tbl[i].e1);
         wait_idle();
         chk($sformatf("rx0_vec%0d", i), acc[0], tbl[i].r0);
         chk($sformatf("rx1_vec%0d", i), acc[1], tbl[i].r1);
      end

      // Write coinciding with the trigger edge: shadow takes the old digit.
      wr(1'b0, 4'd2);
      wr(1'b1, 4'd4);
      wr_en = 1'b1; wr_sel = 1'b0; wr_data = 4'd8;
      trig1(4'd2, 4'd4);
      wr_en = 1'b0;
      wait_idle();
      trig1(4'd8, 4'd4);
      wait_idle();

      // Busy: send toggles and a stage write mid-transfer must not disturb it.
      wr(1'b0, 4'd4);
      wr(1'b1, 4'd6);
      trig1(4'd4, 4'd6);
      tick();
      send1 = 1'b1; tick();
      wr(1'b0, 4'd3);
      send1 = 1'b0; tick();
      send1 = 1'b1; tick();
      send1 = 1'b0;
      wait_idle();
      trig1(4'd3, 4'd6);
      wait_idle();

      // Held send: one transfer only.
      send1 = 1'b1;
      push_xfer(1, 4'd3, 4'd6, 1, 2, 2);
      repeat (30) tick();
      send1 = 1'b0;
      wait_idle();

      // Parameterised timing instance.
      wr(1'b0, 4'd3);
      wr(1'b1, 4'd13);
      send2 = 1'b1;
      push_xfer(2, 4'd3, 4'd3, 3, 1, 4);
      tick();
      send2 = 1'b0;
      wait_idle();

      // Reset during channel-1 pulse.
      wr(1'b0, 4'd1);
      wr(1'b1, 4'd2);
      send1 = 1'b1;
      push_xfer(1, 4'd1, 4'd2, 1, 2, 2);
      tick();
      send1 = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 30 && !found; k++) begin
         if (select1 && add1) found = 1'b1;
         else tick();
      end
      chk("reach_ch1_pulse", found, 1);
      mon_en = 1'b0;
      rst = 1'b1;
      tick();
      chk("midrst_add", add1, 0);
      chk("midrst_busy", busy1, 0);
      chk("midrst_select", select1, 0);
      chk("midrst_data", data1, 0);
      chk("midrst_done", done1, 0);
      rst = 1'b0;
      q1.delete();
      q2.delete();
      tick();
      chk("postrst_done", done1, 0);
      mon_en = 1'b1;
      trig1(4'd0, 4'd0);
      wait_idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/digit_sender.md
Name: digit_sender

Overview:
- Initiator side of the digit-add interface: `select` picks a channel, a rising edge on `add` adds `data_in` (mod 10) to that channel.
- Holds two staged BCD digits, one per channel, written by a host.
- On a `send` trigger, replays them as two well-formed add transactions: channel 0 first, then channel 1.
- Guarantees the setup, pulse-width and low-gap timing that the edge-detecting receiver needs.
- Sits between host/control logic and the two-channel mod-10 accumulator.

Parameters:
- SETUP_CYC, 1, cycles `select`/`data_out` are stable with `add`=0 before the pulse (≥1).
- HOLD_CYC, 2, cycles `add` is held high (≥1).
- GAP_CYC, 2, cycles `add` is held low after the pulse, before the next channel or done (≥1).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write staged digit this cycle.
- wr_sel  in  1  staged-digit index to write.
- wr_data  in  4  digit to stage; reduced mod 10 on write.
- send  in  1  level input; a rising edge (0→1 between consecutive samples) starts a transfer.
- select  out  1  channel currently addressed on the receiver interface.
- add  out  1  add strobe to the receiver.
- data_out  out  4  digit presented to the receiver (`data_in` there).
- busy  out  1  transfer in progress.
- done  out  1  one-cycle pulse when a transfer completes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - staged digits = 0; shadow digits = 0; send history = 0.
  - FSM = IDLE; select=0, add=0, data_out=0, busy=0, done=0.
  - Applies mid-transfer too: the transfer is aborted and `add` drops to 0 on the next edge.
- Staging:
  - wr_en=1 at an edge stores wr_data into stage[wr_sel]; value 10..15 is stored as wr_data−10.
  - Writes are accepted in any state. They never affect a transfer already in progress.
- Trigger:
  - Rising-edge detect = send & ~send_q, where send_q is send registered.
  - In IDLE, a detected edge copies stage[0..1] into shadow[0..1] and moves to SETUP with ch=0.
  - If wr_en and the edge coincide, shadow takes the pre-write stage value.
  - Edges while busy are ignored. They are not queued.
- FSM states, with a down-counter cnt sized $clog2 of max(SETUP_CYC,HOLD_CYC,GAP_CYC)+1:
  - IDLE: select=0, add=0, data_out=0, busy=0.
  - SETUP: select=ch, data_out=shadow[ch], add=0, busy=1. After SETUP_CYC cycles → PULSE.
  - PULSE: same select/data_out, add=1, busy=1. After HOLD_CYC cycles → GAP.
  - GAP: same select/data_out, add=0, busy=1. After GAP_CYC cycles: if ch=0 → SETUP with ch=1; if ch=1 → DONE.
  - DONE: one cycle, done=1, busy=0, all other outputs as IDLE; → IDLE.
- All outputs are registered, driven from the state and counter registers.
- select/data_out change only on SETUP entry, never while add=1.
- Latency with defaults:
  - busy rises on the edge after the trigger edge is sampled.
  - busy lasts 2×(SETUP_CYC+HOLD_CYC+GAP_CYC) = 10 cycles, then done is high for 1 cycle.
  - Minimum spacing between successive accepted sends = 11 cycles.
- Zero digits are still sent (add pulse with data_out=0). The receiver value is unchanged.

Decomposition:
- Shared package `digit_pkg`:
  - state enum {IDLE, SETUP, PULSE, GAP, DONE};
  - constants DIGIT_W=4, DIGIT_MOD=10, NUM_CH=2;
  - the mod-10 reduction function, reused by the receiver side.
- Natural sub-module: `rise_edge_det` (clk, rst, in, pulse), the synchronous-reset rising-edge detector for `send`.

Test Plan:
- Basic transfer:
  - Stimulus: reset; write stage[0]=7, stage[1]=5; raise send and hold it high.
  - Required: select=0/data_out=7 for 1 cycle, then add high 2 cycles, low 2 cycles; then the same for select=1/data_out=5; done pulse once; busy high exactly 10 cycles.
  - With a zeroed receiver attached, its outputs read 7 then 5.
- Mod-10 on write:
  - Stimulus: write stage[0]=12, stage[1]=15; send.
  - Required: data_out shows 2 then 5.
  - Second identical send with a receiver holding 7,5 → receiver ends at 9,0.
- Busy rules:
  - Stimulus: during a transfer, toggle send and write stage[0]=3.
  - Required: no second transfer starts; the current transfer still sends the shadowed values.
  - The next send transmits 3.
- Held send:
  - Stimulus: keep send=1 for 30 cycles.
  - Required: exactly one transfer and one done pulse.
- Reset mid-operation:
  - Stimulus: assert rst during PULSE of channel 1.
  - Required: next edge gives add=0, busy=0, select=0, data_out=0, no done, staged digits=0.
- Timing parameters:
  - Stimulus: instantiate with SETUP_CYC=3, HOLD_CYC=1, GAP_CYC=4.
  - Required: per channel, exactly 3 setup / 1 high / 4 low cycles; busy=16 cycles.
